// File: rtl/hazard_unit_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  localparam logic [1:0] FWD_REG       = 2'b00;
  localparam logic [1:0] FWD_W         = 2'b01;
  localparam logic [1:0] FWD_M         = 2'b10;
  localparam logic [1:0] RESULT_LOAD   = 2'b01;
  localparam logic [2:0] REGWRITE_NONE = 3'b000;

  // The M stage holds the younger result, so it wins over W.
  function automatic logic [1:0] fwd_pick(input logic hit_m, input logic hit_w);
    if (hit_m)      return FWD_M;
    else if (hit_w) return FWD_W;
    else            return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_unit_forwarding.sv
// Combinational operand-bypass selection for the two E-stage source operands.
module forwarding_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic [2:0]                RegWriteM,
  input  logic [2:0]                RegWriteW,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE
);

  logic m_valid;
  logic w_valid;

  // x0 is hardwired to zero, so a write to it is never a bypass source.
  assign m_valid = (RegWriteM != REGWRITE_NONE) && (RdM != '0);
  assign w_valid = (RegWriteW != REGWRITE_NONE) && (RdW != '0);

  assign ForwardAE = fwd_pick(m_valid && (RdM == Rs1E), w_valid && (RdW == Rs1E));
  assign ForwardBE = fwd_pick(m_valid && (RdM == Rs2E), w_valid && (RdW == Rs2E));

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/forward controller for the 5-stage core, with memory-wait
// sequencing, sticky timeout fault and a saturating stall-cycle counter.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int WAIT_LIMIT     = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic [2:0]                RegWriteE,
  input  logic [2:0]                RegWriteM,
  input  logic [2:0]                RegWriteW,
  input  logic [1:0]                ResultsrcE,
  input  logic                      PCsrcE,
  input  logic                      MemAccessM,
  input  logic                      mem_ready,
  output logic                      mem_req,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      StallM,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      FlushW,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      mem_fault,
  output logic [CNT_WIDTH-1:0]      stall_cycles
);

  localparam int WCW = $clog2(WAIT_LIMIT + 1);

  state_t         state;
  logic [WCW-1:0] wait_cnt;
  logic           mem_stall;
  logic           lw_stall;
  logic           req_raw;

  forwarding_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd (
    .Rs1E      (Rs1E),
    .Rs2E      (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE)
  );

  assign lw_stall = (ResultsrcE == RESULT_LOAD) && (RegWriteE != REGWRITE_NONE) &&
                    (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    req_raw   = 1'b0;
    mem_stall = 1'b0;
    case (state)
      RUN: begin
        req_raw   = MemAccessM;
        mem_stall = MemAccessM && !mem_ready;
      end
      MEM_WAIT: begin
        req_raw   = 1'b1;
        mem_stall = !mem_ready;
      end
      FAULT: begin
        mem_stall = 1'b1;
      end
      default: begin
        req_raw   = 1'b0;
        mem_stall = 1'b0;
      end
    endcase
  end

  // Request is gated by reset so it drops the moment reset asserts.
  assign mem_req = req_raw && rst;

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (mem_stall) begin
      // E is frozen, so a pending branch waits for the release cycle.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCsrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      wait_cnt     <= '0;
      mem_fault    <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (StallF && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_WIDTH'(1);
      case (state)
        RUN: begin
          if (MemAccessM && !mem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= WCW'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt >= WCW'(WAIT_LIMIT)) begin
            state     <= FAULT;
            mem_fault <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        FAULT: begin
          mem_fault <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule
